input_debouncer: RTL and testbench
==================================

Name: input_debouncer

Overview:
- Sits directly downstream of the two-flop clock synchronizer.
- Consumes its already-synchronized single-bit output and filters contact bounce or glitches.
- Publishes a stable level plus single-cycle rise/fall event pulses for buttons, switches and slow external strobes.
- Also keeps a saturating count of rejected glitches for debug readout.

Parameters:
- STABLE_CYCLES, 16, number of consecutive clk edges bit_in must differ from level before level changes; legal range 1..65535.
- RESET_LEVEL, 0, value of level (and the initial state) after reset; 0 or 1.
- GLITCH_WIDTH, 8, width of the saturating glitch counter.

Ports:
- clk  input  1  system clock; all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- bit_in  input  1  synchronized input from the clock synchronizer; treated as already in the clk domain
- level  output  1  debounced level
- rise  output  1  one-cycle pulse when level goes 0->1
- fall  output  1  one-cycle pulse when level goes 1->0
- glitch_count  output  GLITCH_WIDTH  saturating count of aborted transitions
- glitch_clear  input  1  synchronous clear of glitch_count

Behaviour:
- Reset (reset_n low, asynchronous):
  - level = RESET_LEVEL, rise = 0, fall = 0, glitch_count = 0.
  - Internal counter = 0; state = STABLE_LOW if RESET_LEVEL = 0, else STABLE_HIGH.
  - Reset asserted mid-check aborts the check; no pulse and no glitch increment. Release is synchronous to the next edge by the system reset logic.
- States: STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW. Internal counter width is clog2(STABLE_CYCLES+1).
- STABLE_LOW, bit_in = 1 at an edge:
  - If STABLE_CYCLES = 1: go straight to STABLE_HIGH, level <= 1, rise <= 1.
  - Otherwise: go to CHECK_HIGH with counter <= 1.
- CHECK_HIGH, bit_in = 1:
  - counter increments.
  - When counter + 1 = STABLE_CYCLES: go to STABLE_HIGH, level <= 1, rise <= 1, counter <= 0.
- CHECK_HIGH, bit_in = 0: go to STABLE_LOW, counter <= 0, glitch_count increments (saturating).
- STABLE_HIGH and CHECK_LOW mirror the above with the polarity swapped, producing fall.
- Latency: level changes after the STABLE_CYCLES-th consecutive edge sampling the new value. rise/fall assert in the same cycle level changes and are high for exactly one cycle.
- rise and fall are never high together. At most one of them is asserted per level change.
- Glitch counter:
  - glitch_count holds at all-ones; it never wraps.
  - glitch_clear has priority over a same-cycle increment, so the result is 0.
  - glitch_clear does not affect the state machine.
- level, rise, fall and glitch_count are all registered outputs with no combinational path from bit_in.
- bit_in held at the current level in a STABLE state: no activity, counter stays 0.

Test Plan:
- Reset with RESET_LEVEL=0, STABLE_CYCLES=4, bit_in=0 -> level=0, rise=fall=0, glitch_count=0; assert reset_n low mid-check -> outputs return to reset values immediately without waiting for clk.
- STABLE_CYCLES=4: bit_in 0->1 held before edge 1 -> level=1 and rise=1 after edge 4, rise=0 after edge 5; no fall.
- STABLE_CYCLES=4: bit_in high for 3 edges then low -> level stays 0, no rise, glitch_count=1; repeat 300 times with GLITCH_WIDTH=8 -> glitch_count saturates at 255.
- level=1, bit_in 1->0 held for 4 edges -> fall one cycle concurrent with level=0; then pulse glitch_clear in the same cycle as a new glitch -> glitch_count=0.
- STABLE_CYCLES=1: toggle bit_in every cycle -> level follows bit_in delayed by one edge, rise/fall alternate each cycle, glitch_count stays 0.
- RESET_LEVEL=1, bit_in=1 out of reset -> level=1, no spurious fall or rise during the first 20 cycles.

Source files
------------

// File: rtl/input_debouncer.sv
// ---------------------------------------------------------------------------
// input_debouncer
//
// Filters contact bounce and short glitches on a single-bit input that has
// already been brought into the clk domain by a two-flop synchronizer.
// The filtered level only changes after the input has held the opposite
// value for STABLE_CYCLES consecutive clock edges. A one-cycle rise or fall
// pulse marks each level change. Every check that is abandoned before it
// completes is counted in a saturating debug counter.
//
// All outputs come straight from flops, so there is no combinational path
// from bit_in to any output.
// ---------------------------------------------------------------------------
module input_debouncer #(
  parameter int unsigned STABLE_CYCLES = 16,   // 1..65535
  parameter bit          RESET_LEVEL   = 1'b0, // level after reset
  parameter int unsigned GLITCH_WIDTH  = 8     // glitch counter width
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    bit_in,
  output logic                    level,
  output logic                    rise,
  output logic                    fall,
  output logic [GLITCH_WIDTH-1:0] glitch_count,
  input  logic                    glitch_clear
);

  // Counter wide enough to hold STABLE_CYCLES itself.
  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

  // A check completes on the edge where counter + 1 == STABLE_CYCLES,
  // i.e. while the registered counter still holds STABLE_CYCLES - 1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [GLITCH_WIDTH-1:0] GLITCH_MAX = '1;

  // STABLE_* : level is settled and bit_in agrees with it.
  // CHECK_*  : bit_in disagrees with level and is being timed.
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHECK_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    CHECK_LOW   = 2'd3
  } state_e;

  localparam state_e RESET_STATE = RESET_LEVEL ? STABLE_HIGH : STABLE_LOW;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    level_q, level_d;
  logic                    rise_q, rise_d;
  logic                    fall_q, fall_d;
  logic [GLITCH_WIDTH-1:0] glitch_q, glitch_d;
  logic                    glitch_hit;

  // State register: FSM, check counter, registered outputs and glitch count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RESET_STATE;
      cnt_q    <= '0;
      level_q  <= RESET_LEVEL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // computed before this edge, independent of statement order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  // Next-state logic: time disagreement between bit_in and level.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    cnt_d      = '0;
    level_d    = level_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_hit = 1'b0;

    unique case (state_q)
      STABLE_LOW: begin
        if (bit_in) begin
          if (STABLE_CYCLES == 1) begin
            state_d = STABLE_HIGH;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = CHECK_HIGH;
            cnt_d   = CNT_W'(1);
          end
        end
      end

      CHECK_HIGH: begin
        if (bit_in) begin
          if (cnt_q == CNT_LAST) begin
            state_d = STABLE_HIGH;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          // Input fell back before the check completed.
          state_d    = STABLE_LOW;
          glitch_hit = 1'b1;
        end
      end

      STABLE_HIGH: begin
        if (!bit_in) begin
          if (STABLE_CYCLES == 1) begin
            state_d = STABLE_LOW;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = CHECK_LOW;
            cnt_d   = CNT_W'(1);
          end
        end
      end

      CHECK_LOW: begin
        if (!bit_in) begin
          if (cnt_q == CNT_LAST) begin
            state_d = STABLE_LOW;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          // Input returned high before the check completed.
          state_d    = STABLE_HIGH;
          glitch_hit = 1'b1;
        end
      end

      default: begin
        state_d = RESET_STATE;
        level_d = RESET_LEVEL;
      end
    endcase
  end

  // Glitch counter update: clear wins over increment; saturates at all-ones.
  always_comb begin
    glitch_d = glitch_q;
    if (glitch_clear) begin
      glitch_d = '0;
    end else if (glitch_hit && (glitch_q != GLITCH_MAX)) begin
      glitch_d = glitch_q + GLITCH_WIDTH'(1);
    end
  end

  // Output logic: ports are driven directly from their flops.
  always_comb begin
    level        = level_q;
    rise         = rise_q;
    fall         = fall_q;
    glitch_count = glitch_q;
  end

endmodule

// File: tb/tb_input_debouncer.sv
// ---------------------------------------------------------------------------
// tb_input_debouncer
//
// Three debouncer instances share clock and reset:
//   dut_a : STABLE_CYCLES=4, RESET_LEVEL=0  (main function, glitches, reset)
//   dut_b : STABLE_CYCLES=1, RESET_LEVEL=0  (single-cycle pass-through)
//   dut_c : STABLE_CYCLES=4, RESET_LEVEL=1  (high reset level)
// Stimulus pushes the expected rise/fall events (instance, cycle, level) into
// a scoreboard queue; a monitor on the falling edge pops and compares each
// pulse the instances produce. Direct checks cover levels and counters.
// ---------------------------------------------------------------------------
module tb_input_debouncer;

  typedef struct {
    int id;
    bit rise;
    bit fall;
    bit level;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       a_bit, b_bit, c_bit;
  logic       a_clr, b_clr, c_clr;
  logic       a_level, a_rise, a_fall;
  logic       b_level, b_rise, b_fall;
  logic       c_level, c_rise, c_fall;
  logic [7:0] a_gc, b_gc, c_gc;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb[$];

  input_debouncer #(.STABLE_CYCLES(4), .RESET_LEVEL(1'b0), .GLITCH_WIDTH(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .bit_in(a_bit), .level(a_level), .rise(a_rise),
    .fall(a_fall), .glitch_count(a_gc), .glitch_clear(a_clr));

  input_debouncer #(.STABLE_CYCLES(1), .RESET_LEVEL(1'b0), .GLITCH_WIDTH(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .bit_in(b_bit), .level(b_level), .rise(b_rise),
    .fall(b_fall), .glitch_count(b_gc), .glitch_clear(b_clr));

  input_debouncer #(.STABLE_CYCLES(4), .RESET_LEVEL(1'b1), .GLITCH_WIDTH(8)) dut_c (
    .clk(clk), .reset_n(reset_n), .bit_in(c_bit), .level(c_level), .rise(c_rise),
    .fall(c_fall), .glitch_count(c_gc), .glitch_clear(c_clr));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_evt(input int id, input bit r, input bit f, input bit l, input int at);
    exp_t e;
    e.id    = id;
    e.rise  = r;
    e.fall  = f;
    e.level = l;
    e.cyc   = at;
    sb.push_back(e);
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every pulse from any instance must match the scoreboard head.
  task automatic observe(input int id, input logic r, input logic f, input logic l);
    exp_t e;
    if (r || f) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected dut=%0d cyc=%0d got rise=%0b fall=%0b level=%0b expected no event",
                 id, cyc, r, f, l);
      end else begin
        e = sb.pop_front();
        if (e.id != id || e.cyc != cyc || e.rise != r || e.fall != f || e.level != l) begin
          failures++;
          $display("FAIL sb_event got dut=%0d cyc=%0d rise=%0b fall=%0b level=%0b expected dut=%0d cyc=%0d rise=%0b fall=%0b level=%0b",
                   id, cyc, r, f, l, e.id, e.cyc, e.rise, e.fall, e.level);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    observe(0, a_rise, a_fall, a_level);
    observe(1, b_rise, b_fall, b_level);
    observe(2, c_rise, c_fall, c_level);
  end

  initial begin
    reset_n = 1'b0;
    a_bit = 1'b0; b_bit = 1'b0; c_bit = 1'b1;
    a_clr = 1'b0; b_clr = 1'b0; c_clr = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(1);

    // Reset state
    check("a_reset_level", a_level, 0);
    check("a_reset_rise",  a_rise, 0);
    check("a_reset_fall",  a_fall, 0);
    check("a_reset_gc",    a_gc, 0);
    check("c_reset_level", c_level, 1);

    // Rise after exactly 4 edges, one-cycle pulse
    a_bit = 1'b1;
    expect_evt(0, 1, 0, 1, cyc + 4);
    tick(3);
    check("a_rise_edge3_level", a_level, 0);
    tick(1);
    check("a_rise_edge4_level", a_level, 1);
    check("a_rise_edge4_pulse", a_rise, 1);
    tick(1);
    check("a_rise_edge5_pulse", a_rise, 0);
    check("a_rise_edge5_fall",  a_fall, 0);

    // Fall after 4 edges, concurrent with level=0
    a_bit = 1'b0;
    expect_evt(0, 0, 1, 0, cyc + 4);
    tick(4);
    check("a_fall_level", a_level, 0);
    check("a_fall_pulse", a_fall, 1);
    tick(1);
    check("a_fall_pulse_end", a_fall, 0);

    // 300 glitches of 3 edges each: count then saturate at 255
    for (int i = 1; i <= 300; i++) begin
      a_bit = 1'b1;
      tick(3);
      a_bit = 1'b0;
      tick(1);
      if (i == 1) begin
        check("a_glitch_first_gc", a_gc, 1);
        check("a_glitch_first_level", a_level, 0);
      end
      if (i == 255) check("a_glitch_255_gc", a_gc, 255);
    end
    check("a_glitch_sat_gc", a_gc, 255);
    check("a_glitch_sat_level", a_level, 0);

    // Clear in the same cycle as a new glitch: clear wins
    a_bit = 1'b1;
    tick(3);
    a_bit = 1'b0;
    a_clr = 1'b1;
    tick(1);
    a_clr = 1'b0;
    check("a_clear_vs_glitch_gc", a_gc, 0);

    // Clear during a check does not disturb the FSM timing
    a_bit = 1'b1;
    expect_evt(0, 1, 0, 1, cyc + 4);
    tick(2);
    a_clr = 1'b1;
    tick(1);
    a_clr = 1'b0;
    tick(2);
    check("a_clear_midcheck_level", a_level, 1);
    check("a_clear_midcheck_gc", a_gc, 0);

    // Glitch while high
    a_bit = 1'b0;
    tick(3);
    a_bit = 1'b1;
    tick(1);
    check("a_glitch_high_gc", a_gc, 1);
    check("a_glitch_high_level", a_level, 1);

    // Reset mid-check (CHECK_LOW) takes effect without a clock edge
    a_bit = 1'b0;
    tick(2);
    #2;
    reset_n = 1'b0;
    #1;
    check("a_async_reset_level", a_level, 0);
    check("a_async_reset_gc", a_gc, 0);
    check("a_async_reset_fall", a_fall, 0);
    check("c_async_reset_level", c_level, 1);
    tick(1);
    reset_n = 1'b1;
    tick(6);
    check("a_post_reset_level", a_level, 0);
    check("a_post_reset_gc", a_gc, 0);

    // STABLE_CYCLES=1: level follows bit_in one edge later, alternating pulses
    for (int i = 0; i < 10; i++) begin
      b_bit = ~b_bit;
      expect_evt(1, b_bit, ~b_bit, b_bit, cyc + 1);
      tick(1);
      check("b_follow_level", b_level, b_bit);
    end
    tick(2);
    check("b_gc", b_gc, 0);

    // RESET_LEVEL=1: quiet for 20 cycles, then a normal fall
    tick(20);
    check("c_quiet_level", c_level, 1);
    check("c_quiet_gc", c_gc, 0);
    c_bit = 1'b0;
    expect_evt(2, 0, 1, 0, cyc + 4);
    tick(5);
    check("c_fall_level", c_level, 0);

    tick(4);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
